// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the memory-stage exception controller.
// Holds the exception type encodings, exception flag bit positions, CP0
// register addresses, the default exception vector and the FSM states.
package exc_ctrl_pkg;

  localparam int EXC_TYPE_W = 4;

  typedef enum logic [EXC_TYPE_W-1:0] {
    EXC_NONE = 4'd0,
    EXC_INT  = 4'd1,
    EXC_IF   = 4'd2,
    EXC_RI   = 4'd3,
    EXC_OV   = 4'd4,
    EXC_BP   = 4'd5,
    EXC_SYS  = 4'd6,
    EXC_ADEL = 4'd7,
    EXC_ADES = 4'd8,
    EXC_ERET = 4'd9
  } exc_type_e;

  // Bit positions inside mem_exc_flags_i
  localparam int FLAG_IF   = 0;
  localparam int FLAG_RI   = 1;
  localparam int FLAG_OV   = 2;
  localparam int FLAG_BP   = 3;
  localparam int FLAG_SYS  = 4;
  localparam int FLAG_ADEL = 5;
  localparam int FLAG_ADES = 6;
  localparam int FLAG_ERET = 7;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_e;

endpackage

// File: rtl/exc_prio.sv
// Purpose: fixed-priority encoder, exception flags plus interrupt -> type.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: flags_i (per-instruction flags), int_i (interrupt taken),
//        exc_type_o (highest-priority exception, NONE when nothing set).
module exc_prio
  import exc_ctrl_pkg::*;
(
  input  logic [7:0] flags_i,
  input  logic       int_i,
  output logic [3:0] exc_type_o
);

  always_comb begin
    exc_type_o = EXC_NONE;
    if (int_i)                        exc_type_o = EXC_INT;
    else if (flags_i[FLAG_IF])        exc_type_o = EXC_IF;
    else if (flags_i[FLAG_RI])        exc_type_o = EXC_RI;
    else if (flags_i[FLAG_OV])        exc_type_o = EXC_OV;
    else if (flags_i[FLAG_BP])        exc_type_o = EXC_BP;
    else if (flags_i[FLAG_SYS])       exc_type_o = EXC_SYS;
    else if (flags_i[FLAG_ADEL])      exc_type_o = EXC_ADEL;
    else if (flags_i[FLAG_ADES])      exc_type_o = EXC_ADES;
    else if (flags_i[FLAG_ERET])      exc_type_o = EXC_ERET;
  end

endmodule

// File: rtl/exc_ctrl.sv
// Purpose: MEM-stage exception controller; picks one exception for CP0,
//          pulses a pipeline flush and offers a redirect PC to fetch.
// Latency: exc_type_o/flush_o combinational in the take cycle; redirect
//          offered from the next cycle.
// Backpressure: redirect held stable until redirect_ready_i; no new take
//          while a redirect is pending; mem_stall_i blocks a take.
// Ports: MEM instruction info (mem_*_i), CP0 values (cp0_*_i), WB MTC0
//        write (wb_cp0_*_i), CP0 side-band (exc_*_o), flush_o,
//        redirect valid/ready/pc, int_pending_o.
// Config: define EXC_CTRL_CP0_BYPASS_EN to forward the in-flight WB MTC0
//         write into the effective STATUS/CAUSE/EPC values.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [7:0]  mem_exc_flags_i,
  input  logic [31:0] mem_data_addr_i,
  input  logic        mem_stall_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_wdata_i,
  output logic [3:0]  exc_type_o,
  output logic [31:0] exc_pc_o,
  output logic        exc_delayslot_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i,
  output logic        int_pending_o
);

  state_e      state_q;
  logic        int_pending_q, int_pending_d;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic [31:0] eff_status, eff_cause, eff_epc;
  logic        int_cond;
  logic        can_take;
  logic        int_taken;
  logic        take;
  logic [3:0]  prio_type;

`ifdef EXC_CTRL_CP0_BYPASS_EN
  // Forward an MTC0 still sitting in WB so the MEM instruction sees it.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (wb_cp0_we_i) begin
      case (wb_cp0_waddr_i)
        CP0_STATUS: eff_status = wb_cp0_wdata_i;
        // Only the software interrupt bits of CAUSE are writable.
        CP0_CAUSE:  eff_cause  = {cp0_cause_i[31:10], wb_cp0_wdata_i[9:8],
                                  cp0_cause_i[7:0]};
        CP0_EPC:    eff_epc    = wb_cp0_wdata_i;
        default:    ;
      endcase
    end
  end
`else
  assign eff_status = cp0_status_i;
  assign eff_cause  = cp0_cause_i;
  assign eff_epc    = cp0_epc_i;

  logic unused_wb;
  assign unused_wb = ^{wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_wdata_i};
`endif

  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{eff_status[31:16], eff_status[7:2],
                             eff_cause[31:16], eff_cause[7:0]};

  assign int_cond = eff_status[0] && !eff_status[1] &&
                    ((eff_cause[15:8] & eff_status[15:8]) != 8'h00);

  assign can_take  = (state_q == ST_IDLE) && mem_valid_i && !mem_stall_i;
  assign int_taken = can_take && int_pending_q;
  assign take      = can_take && (int_pending_q || (mem_exc_flags_i != 8'h00));

  // A bubble in MEM leaves the interrupt pending for the next real instruction.
  assign int_pending_d = int_cond && !int_taken;

  exc_prio u_prio (
    .flags_i    (mem_exc_flags_i),
    .int_i      (int_pending_q),
    .exc_type_o (prio_type)
  );

  assign exc_type_o      = take ? prio_type : EXC_NONE;
  assign flush_o         = take;
  assign exc_pc_o        = mem_pc_i;
  assign exc_delayslot_o = mem_in_delayslot_i;

  always_comb begin
    exc_badvaddr_o = 32'h0;
    case (exc_type_o)
      EXC_IF:             exc_badvaddr_o = mem_pc_i;
      EXC_ADEL, EXC_ADES: exc_badvaddr_o = mem_data_addr_i;
      default:            ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      int_pending_q    <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
    end else begin
      int_pending_q <= int_pending_d;
      case (state_q)
        ST_IDLE: begin
          if (take) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            redirect_pc_q    <= (prio_type == EXC_ERET) ? eff_epc : EXC_VECTOR;
          end
        end
        ST_REDIRECT: begin
          if (redirect_valid_q && redirect_ready_i) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          redirect_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;
  assign int_pending_o    = int_pending_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed testbench for exc_ctrl: inputs driven just after the falling
// edge, outputs sampled 1ns later, registered state observed after the
// following rising edge.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid_i = 1'b0;
  logic [31:0] mem_pc_i = 32'h0;
  logic        mem_in_delayslot_i = 1'b0;
  logic [7:0]  mem_exc_flags_i = 8'h0;
  logic [31:0] mem_data_addr_i = 32'h0;
  logic        mem_stall_i = 1'b0;
  logic [31:0] cp0_status_i = 32'h0;
  logic [31:0] cp0_cause_i = 32'h0;
  logic [31:0] cp0_epc_i = 32'h0;
  logic        wb_cp0_we_i = 1'b0;
  logic [4:0]  wb_cp0_waddr_i = 5'h0;
  logic [31:0] wb_cp0_wdata_i = 32'h0;
  logic [3:0]  exc_type_o;
  logic [31:0] exc_pc_o;
  logic        exc_delayslot_o;
  logic [31:0] exc_badvaddr_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic        redirect_ready_i = 1'b1;
  logic        int_pending_o;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  int n_checks = 0;
  int n_fail   = 0;

  exc_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .mem_valid_i        (mem_valid_i),
    .mem_pc_i           (mem_pc_i),
    .mem_in_delayslot_i (mem_in_delayslot_i),
    .mem_exc_flags_i    (mem_exc_flags_i),
    .mem_data_addr_i    (mem_data_addr_i),
    .mem_stall_i        (mem_stall_i),
    .cp0_status_i       (cp0_status_i),
    .cp0_cause_i        (cp0_cause_i),
    .cp0_epc_i          (cp0_epc_i),
    .wb_cp0_we_i        (wb_cp0_we_i),
    .wb_cp0_waddr_i     (wb_cp0_waddr_i),
    .wb_cp0_wdata_i     (wb_cp0_wdata_i),
    .exc_type_o         (exc_type_o),
    .exc_pc_o           (exc_pc_o),
    .exc_delayslot_o    (exc_delayslot_o),
    .exc_badvaddr_o     (exc_badvaddr_o),
    .flush_o            (flush_o),
    .redirect_valid_o   (redirect_valid_o),
    .redirect_pc_o      (redirect_pc_o),
    .redirect_ready_i   (redirect_ready_i),
    .int_pending_o      (int_pending_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts just after a falling edge in IDLE with redirect_ready_i=1.
  // Presents one instruction, checks the take cycle, the redirect cycle
  // and the return to IDLE.
  task automatic fire(input string tag, input logic [7:0] flags, input logic [31:0] pc,
                      input logic [31:0] addr, input logic ds, input logic [3:0] exp_type,
                      input logic [31:0] exp_bad, input logic [31:0] exp_rpc);
    mem_valid_i        = 1'b1;
    mem_exc_flags_i    = flags;
    mem_pc_i           = pc;
    mem_data_addr_i    = addr;
    mem_in_delayslot_i = ds;
    #1;
    check({tag, "_type"},  32'(exc_type_o), 32'(exp_type));
    check({tag, "_flush"}, 32'(flush_o), 32'd1);
    check({tag, "_bad"},   exc_badvaddr_o, exp_bad);
    check({tag, "_epc"},   exc_pc_o, pc);
    check({tag, "_ds"},    32'(exc_delayslot_o), 32'(ds));
    @(posedge clk);
    @(negedge clk);
    mem_valid_i     = 1'b0;
    mem_exc_flags_i = 8'h00;
    #1;
    check({tag, "_rvld"},   32'(redirect_valid_o), 32'd1);
    check({tag, "_rpc"},    redirect_pc_o, exp_rpc);
    check({tag, "_noflush"}, 32'(flush_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "_rdone"}, 32'(redirect_valid_o), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rvld", 32'(redirect_valid_o), 32'd0);
    check("rst_rpc",  redirect_pc_o, 32'h0);
    check("rst_int",  32'(int_pending_o), 32'd0);
    check("rst_type", 32'(exc_type_o), 32'd0);
    check("rst_flush", 32'(flush_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Priority and side-band
    fire("ri_ov",   8'h06, 32'h8000_0010, 32'h0, 1'b0, 4'd3, 32'h0, VEC);
    fire("ades",    8'h40, 32'h8000_0020, 32'h8000_0003, 1'b1, 4'd8, 32'h8000_0003, VEC);
    fire("if_all",  8'hFF, 32'h8000_0030, 32'h1234_5678, 1'b0, 4'd2, 32'h8000_0030, VEC);
    fire("bp_sys",  8'h18, 32'h8000_0034, 32'h0, 1'b0, 4'd5, 32'h0, VEC);
    fire("sys_adel", 8'h30, 32'h8000_0038, 32'h8000_0005, 1'b0, 4'd6, 32'h0, VEC);
    fire("adel_ades", 8'h60, 32'h8000_003C, 32'h8000_0006, 1'b0, 4'd7, 32'h8000_0006, VEC);
    cp0_epc_i = 32'h8000_0500;
    fire("eret",    8'h80, 32'h8000_0044, 32'h0, 1'b0, 4'd9, 32'h0, 32'h8000_0500);

    // Bubble with flags set: nothing is taken
    mem_valid_i = 1'b0;
    mem_exc_flags_i = 8'h04;
    #1;
    check("bubble_type",  32'(exc_type_o), 32'd0);
    check("bubble_flush", 32'(flush_o), 32'd0);
    @(negedge clk);

    // Stall blocks the take, retried after release
    mem_valid_i = 1'b1;
    mem_exc_flags_i = 8'h10;
    mem_stall_i = 1'b1;
    #1;
    check("stall_type",  32'(exc_type_o), 32'd0);
    check("stall_flush", 32'(flush_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("stall_rvld", 32'(redirect_valid_o), 32'd0);
    mem_stall_i = 1'b0;
    fire("stall_rel", 8'h10, 32'h8000_0048, 32'h0, 1'b0, 4'd6, 32'h0, VEC);

    // Interrupt pending across bubbles
    @(negedge clk);
    mem_valid_i = 1'b0;
    cp0_status_i = 32'h0000_0401;
    cp0_cause_i  = 32'h0000_0400;
    #1;
    check("int_lat0", 32'(int_pending_o), 32'd0);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("int_bub_pend", 32'(int_pending_o), 32'd1);
      check("int_bub_type", 32'(exc_type_o), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    mem_valid_i = 1'b1;
    mem_exc_flags_i = 8'h02;
    mem_pc_i = 32'h8000_0060;
    #1;
    check("int_type",  32'(exc_type_o), 32'd1);
    check("int_flush", 32'(flush_o), 32'd1);
    check("int_bad",   exc_badvaddr_o, 32'h0);
    @(posedge clk);
    @(negedge clk);
    // CP0 sets EXL on exception entry
    cp0_status_i = 32'h0000_0403;
    mem_valid_i = 1'b0;
    mem_exc_flags_i = 8'h00;
    #1;
    check("int_clr",  32'(int_pending_o), 32'd0);
    check("int_rvld", 32'(redirect_valid_o), 32'd1);
    check("int_rpc",  redirect_pc_o, VEC);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("int_stay_clr", 32'(int_pending_o), 32'd0);
    check("int_rdone", 32'(redirect_valid_o), 32'd0);
    cp0_status_i = 32'h0;
    cp0_cause_i  = 32'h0;
    @(negedge clk);

    // ERET with a WB write to EPC in flight
    cp0_epc_i = 32'h8000_0100;
    wb_cp0_we_i = 1'b1;
    wb_cp0_waddr_i = 5'd14;
    wb_cp0_wdata_i = 32'h8000_0200;
`ifdef EXC_CTRL_CP0_BYPASS_EN
    fire("eret_wb", 8'h80, 32'h8000_0070, 32'h0, 1'b0, 4'd9, 32'h0, 32'h8000_0200);
`else
    fire("eret_wb", 8'h80, 32'h8000_0070, 32'h0, 1'b0, 4'd9, 32'h0, 32'h8000_0100);
`endif
    wb_cp0_we_i = 1'b0;

    // Redirect held off by fetch while MEM shows BP
    mem_valid_i = 1'b1;
    mem_exc_flags_i = 8'h08;
    mem_pc_i = 32'h8000_0080;
    redirect_ready_i = 1'b0;
    #1;
    check("hold_type", 32'(exc_type_o), 32'd5);
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("hold_rvld",  32'(redirect_valid_o), 32'd1);
      check("hold_flush", 32'(flush_o), 32'd0);
      check("hold_type0", 32'(exc_type_o), 32'd0);
      check("hold_rpc",   redirect_pc_o, VEC);
      @(posedge clk);
    end
    @(negedge clk);
    redirect_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_exc_flags_i = 8'h00;
    #1;
    check("hold_done", 32'(redirect_valid_o), 32'd0);
    @(negedge clk);

    // Reset while a redirect is pending
    mem_valid_i = 1'b1;
    mem_exc_flags_i = 8'h02;
    redirect_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    mem_valid_i = 1'b0;
    mem_exc_flags_i = 8'h00;
    #1;
    check("mid_rvld", 32'(redirect_valid_o), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_rvld", 32'(redirect_valid_o), 32'd0);
    check("mid_rst_rpc",  redirect_pc_o, 32'h0);
    check("mid_rst_flush", 32'(flush_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    redirect_ready_i = 1'b1;
    @(negedge clk);
    fire("post_rst", 8'h04, 32'h8000_0090, 32'h0, 1'b1, 4'd4, 32'h0, VEC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
